// File: rtl/rvic_axil_arbiter.sv
// -----------------------------------------------------------------------------
// rvic_axil_arbiter
//   Round-robin arbiter that shares one AXI-lite slave port among NumReq
//   upstream requesters. Only one transaction is in flight at a time, so no
//   ID tracking is needed. AW and W of a write are granted together; R and B
//   responses are routed back to the granted requester only.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_aw*/s_w*/s_ar*              per-requester request channels (flat, req i at slice i)
//   s_r*/s_b*                     per-requester response handshakes, shared data buses
//   m_aw*/m_w*/m_ar*              request channels towards the slave
//   m_r*/m_b*                     response channels from the slave
//   busy_o                        high whenever a transaction is being served
// -----------------------------------------------------------------------------
module rvic_axil_arbiter #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    // upstream requesters
    input  logic [NumReq*AddrWidth-1:0]      s_awaddr,
    input  logic [NumReq*3-1:0]              s_awsize,
    input  logic [NumReq-1:0]                s_awvalid,
    output logic [NumReq-1:0]                s_awready,
    input  logic [NumReq*DataWidth-1:0]      s_wdata,
    input  logic [NumReq*(DataWidth/8)-1:0]  s_wstrb,
    input  logic [NumReq-1:0]                s_wvalid,
    output logic [NumReq-1:0]                s_wready,
    input  logic [NumReq*AddrWidth-1:0]      s_araddr,
    input  logic [NumReq*3-1:0]              s_arsize,
    input  logic [NumReq-1:0]                s_arvalid,
    output logic [NumReq-1:0]                s_arready,
    output logic [DataWidth-1:0]             s_rdata,
    output logic [1:0]                       s_rresp,
    output logic [NumReq-1:0]                s_rvalid,
    input  logic [NumReq-1:0]                s_rready,
    output logic [1:0]                       s_bresp,
    output logic [NumReq-1:0]                s_bvalid,
    input  logic [NumReq-1:0]                s_bready,
    // downstream slave
    output logic [AddrWidth-1:0]             m_awaddr,
    output logic [2:0]                       m_awsize,
    output logic                             m_awvalid,
    input  logic                             m_awready,
    output logic [DataWidth-1:0]             m_wdata,
    output logic [DataWidth/8-1:0]           m_wstrb,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    output logic [AddrWidth-1:0]             m_araddr,
    output logic [2:0]                       m_arsize,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    input  logic [DataWidth-1:0]             m_rdata,
    input  logic [1:0]                       m_rresp,
    input  logic                             m_rvalid,
    output logic                             m_rready,
    input  logic [1:0]                       m_bresp,
    input  logic                             m_bvalid,
    output logic                             m_bready,
    output logic                             busy_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int PtrW      = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] grant_q, grant_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [NumReq-1:0] wr_elig_s;
    logic [NumReq-1:0] rd_elig_s;
    logic              found_s;
    logic [PtrW-1:0]   pick_s;
    logic              pick_wr_s;
    logic [PtrW-1:0]   next_ptr_s;
    int                grant_idx_s;

    assign wr_elig_s   = s_awvalid & s_wvalid;
    assign rd_elig_s   = s_arvalid;
    assign grant_idx_s = int'(grant_q);
    assign busy_o      = (state_q != ST_IDLE);

    // Pointer moves to the requester just after the one that was served.
    assign next_ptr_s = (grant_idx_s == NumReq - 1) ? {PtrW{1'b0}} : grant_q + PtrW'(1);

    // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
    // A write-eligible requester is taken as a write even if it also reads.
    always_comb begin
        int  idx;
        logic hit;
        found_s   = 1'b0;
        pick_s    = {PtrW{1'b0}};
        pick_wr_s = 1'b0;
        idx       = 0;
        hit       = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx       = (int'(rr_ptr_q) + k >= NumReq) ? int'(rr_ptr_q) + k - NumReq
                                                       : int'(rr_ptr_q) + k;
            hit       = !found_s && (wr_elig_s[idx] || rd_elig_s[idx]);
            pick_s    = hit ? PtrW'(idx) : pick_s;
            pick_wr_s = hit ? wr_elig_s[idx] : pick_wr_s;
            found_s   = found_s | hit;
        end
    end

    // Next-state logic of the transaction FSM and its bookkeeping registers.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d   = pick_s;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = pick_wr_s ? ST_WR_ADDR : ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                // AW and W may complete in either order or in the same cycle.
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid && s_bready[grant_idx_s]) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rr_ptr_d  = next_ptr_s;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    state_d = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_RESP: begin
                if (m_rvalid && s_rready[grant_idx_s]) begin
                    rr_ptr_d = next_ptr_s;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Channel routing: handshakes pass straight through for the granted
    // requester only; payload buses are zero outside the phase that uses them.
    always_comb begin
        s_awready = {NumReq{1'b0}};
        s_wready  = {NumReq{1'b0}};
        s_arready = {NumReq{1'b0}};
        s_rvalid  = {NumReq{1'b0}};
        s_bvalid  = {NumReq{1'b0}};
        s_rdata   = {DataWidth{1'b0}};
        s_rresp   = 2'b00;
        s_bresp   = 2'b00;
        m_awaddr  = {AddrWidth{1'b0}};
        m_awsize  = 3'b000;
        m_awvalid = 1'b0;
        m_wdata   = {DataWidth{1'b0}};
        m_wstrb   = {StrbWidth{1'b0}};
        m_wvalid  = 1'b0;
        m_araddr  = {AddrWidth{1'b0}};
        m_arsize  = 3'b000;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_bready  = 1'b0;
        case (state_q)
            ST_WR_ADDR: begin
                m_awvalid                = !aw_done_q;
                m_wvalid                 = !w_done_q;
                m_awaddr                 = s_awaddr[grant_idx_s*AddrWidth +: AddrWidth];
                m_awsize                 = s_awsize[grant_idx_s*3 +: 3];
                m_wdata                  = s_wdata[grant_idx_s*DataWidth +: DataWidth];
                m_wstrb                  = s_wstrb[grant_idx_s*StrbWidth +: StrbWidth];
                s_awready[grant_idx_s]   = m_awready & !aw_done_q;
                s_wready[grant_idx_s]    = m_wready & !w_done_q;
            end
            ST_WR_RESP: begin
                m_bready                 = s_bready[grant_idx_s];
                s_bvalid[grant_idx_s]    = m_bvalid;
                s_bresp                  = m_bresp;
            end
            ST_RD_ADDR: begin
                m_arvalid                = 1'b1;
                m_araddr                 = s_araddr[grant_idx_s*AddrWidth +: AddrWidth];
                m_arsize                 = s_arsize[grant_idx_s*3 +: 3];
                s_arready[grant_idx_s]   = m_arready;
            end
            ST_RD_RESP: begin
                m_rready                 = s_rready[grant_idx_s];
                s_rvalid[grant_idx_s]    = m_rvalid;
                s_rdata                  = m_rdata;
                s_rresp                  = m_rresp;
            end
            default: begin
                m_rready = 1'b0;
            end
        endcase
    end

    // State, grant, round-robin pointer and write-phase completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= {PtrW{1'b0}};
            rr_ptr_q  <= {PtrW{1'b0}};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_rvic_axil_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rvic_axil_arbiter
//   Directed, self-checking bench for rvic_axil_arbiter (4 requesters,
//   64-bit address/data). Inputs change and outputs are sampled 2-3 ns after
//   the rising edge, well away from it.
// -----------------------------------------------------------------------------
module tb_rvic_axil_arbiter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [255:0]   s_awaddr, s_araddr, s_wdata;
    logic [11:0]    s_awsize, s_arsize;
    logic [31:0]    s_wstrb;
    logic [3:0]     s_awvalid, s_wvalid, s_arvalid, s_rready, s_bready;
    logic [3:0]     s_awready, s_wready, s_arready, s_rvalid, s_bvalid;
    logic [63:0]    s_rdata;
    logic [1:0]     s_rresp, s_bresp;
    logic [63:0]    m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]     m_awsize, m_arsize;
    logic [7:0]     m_wstrb;
    logic           m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
    logic [1:0]     m_rresp, m_bresp;
    logic           m_rvalid, m_rready, m_bvalid, m_bready, busy_o;

    int checks = 0;
    int errors = 0;

    rvic_axil_arbiter #(.NumReq(4), .AddrWidth(64), .DataWidth(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        s_awaddr = 256'd0; s_araddr = 256'd0; s_wdata = 256'd0;
        s_awsize = 12'd0; s_arsize = 12'd0; s_wstrb = 32'd0;
        s_awvalid = 4'd0; s_wvalid = 4'd0; s_arvalid = 4'd0; s_rready = 4'd0; s_bready = 4'd0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_rdata = 64'd0; m_rresp = 2'd0; m_rvalid = 1'b0; m_bresp = 2'd0; m_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_awaddr = {256{1'b1}}; s_araddr = {256{1'b1}}; s_wdata = {256{1'b1}};
        s_awvalid = 4'hf; s_wvalid = 4'hf; s_arvalid = 4'hf; s_rready = 4'hf; s_bready = 4'hf;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_rvalid = 1'b1; m_bvalid = 1'b1; m_rdata = {64{1'b1}}; m_bresp = 2'b11;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_rready, m_bready} !== 5'b0) begin errors++; $display("FAIL reset_m_hs got %05b want 00000", {m_awvalid, m_wvalid, m_arvalid, m_rready, m_bready}); end
        checks++; if ({s_awready, s_wready, s_arready, s_rvalid, s_bvalid} !== 20'h0) begin errors++; $display("FAIL reset_s_hs got %05h want 0", {s_awready, s_wready, s_arready, s_rvalid, s_bvalid}); end
        checks++; if ({m_awaddr, m_wdata, m_araddr, s_rdata} !== 256'd0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
        checks++; if (s_bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got %0b want 00", s_bresp); end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        s_awaddr[128 +: 64] = 64'he200000004; s_awsize[6 +: 3] = 3'b011;
        s_wdata[128 +: 64] = 64'h1122334455667788; s_wstrb[16 +: 8] = 8'hff;
        s_awvalid = 4'b0100; s_wvalid = 4'b0100; s_bready = 4'b0100;
        m_awready = 1'b1; m_wready = 1'b1;
        #1;
        checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL wr_latency got %0b want 0", m_awvalid); end
        tick();
        checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin errors++; $display("FAIL wr_valids got %02b want 11", {m_awvalid, m_wvalid}); end
        checks++; if (m_awaddr !== 64'he200000004) begin errors++; $display("FAIL wr_awaddr got %0h want e200000004", m_awaddr); end
        checks++; if (m_awsize !== 3'b011) begin errors++; $display("FAIL wr_awsize got %0d want 3", m_awsize); end
        checks++; if ({m_wdata, m_wstrb} !== {64'h1122334455667788, 8'hff}) begin errors++; $display("FAIL wr_wdata got %0h/%0h want 1122334455667788/ff", m_wdata, m_wstrb); end
        checks++; if ({s_awready, s_wready} !== 8'b0100_0100) begin errors++; $display("FAIL wr_readys got %08b want 01000100", {s_awready, s_wready}); end
        tick();
        s_awvalid = 4'b0000; s_wvalid = 4'b0000; m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        checks++; if ({m_awvalid, m_wvalid} !== 2'b00) begin errors++; $display("FAIL wr_resp_valids got %02b want 00", {m_awvalid, m_wvalid}); end
        checks++; if (s_bvalid !== 4'b0100) begin errors++; $display("FAIL wr_bvalid got %04b want 0100", s_bvalid); end
        checks++; if ({s_bresp, m_bready} !== 3'b101) begin errors++; $display("FAIL wr_bresp got %03b want 101", {s_bresp, m_bready}); end
        tick();
        m_bvalid = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_idle got %0b want 0", busy_o); end
        // Pointer is now 3: requesters 0 and 3 both reading -> 3 wins.
        s_arvalid = 4'b1001; m_arready = 1'b1;
        tick();
        checks++; if (s_arready !== 4'b1000) begin errors++; $display("FAIL wr_ptr_next got %04b want 1000", s_arready); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_oh;
        do_reset();
        for (int i = 0; i < 4; i++) s_araddr[i*64 +: 64] = 64'h1000 + 64'(i);
        s_arvalid = 4'hf; m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 4'hf;
        m_rdata = 64'h0123456789abcdef;
        #1;
        for (int t = 0; t < 6; t++) begin
            int n;
            n = 0;
            exp_oh = 4'b0001 << (t % 4);
            while (m_arvalid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++; if (n >= 10) begin errors++; $display("FAIL fair_timeout txn %0d got no arvalid want arvalid", t); end
            checks++; if (s_arready !== exp_oh) begin errors++; $display("FAIL fair_grant txn %0d got %04b want %04b", t, s_arready, exp_oh); end
            checks++; if (m_araddr !== 64'h1000 + 64'(t % 4)) begin errors++; $display("FAIL fair_araddr txn %0d got %0h want %0h", t, m_araddr, 64'h1000 + 64'(t % 4)); end
            tick();
            checks++; if (s_rvalid !== exp_oh) begin errors++; $display("FAIL fair_rvalid txn %0d got %04b want %04b", t, s_rvalid, exp_oh); end
            tick();
        end
    endtask

    task automatic test_split_aw_w();
        do_reset();
        s_awaddr[64 +: 64] = 64'h0200_4000; s_wdata[64 +: 64] = 64'h55aa;
        s_awvalid = 4'b0010; s_wvalid = 4'b0010;
        tick();
        m_awready = 1'b1;
        #1;
        checks++; if ({m_awvalid, s_awready, s_wready} !== 9'b1_0010_0000) begin errors++; $display("FAIL split_n got %09b want 100100000", {m_awvalid, s_awready, s_wready}); end
        tick();
        s_awvalid = 4'b0000;
        #1;
        checks++; if ({m_awvalid, s_awready, m_wvalid} !== 6'b0_0000_1) begin errors++; $display("FAIL split_aw_once got %06b want 000001", {m_awvalid, s_awready, m_wvalid}); end
        tick();
        checks++; if ({m_awvalid, m_wvalid} !== 2'b01) begin errors++; $display("FAIL split_n2 got %02b want 01", {m_awvalid, m_wvalid}); end
        tick();
        m_wready = 1'b1;
        #1;
        checks++; if ({m_wvalid, s_wready} !== 5'b1_0010) begin errors++; $display("FAIL split_n3 got %05b want 10010", {m_wvalid, s_wready}); end
        tick();
        s_wvalid = 4'b0000; s_bready = 4'b0010;
        #1;
        checks++; if ({m_wvalid, s_wready, m_bready, busy_o} !== 7'b0_0000_11) begin errors++; $display("FAIL split_wr_resp got %07b want 0000011", {m_wvalid, s_wready, m_bready, busy_o}); end
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL split_idle got %0b want 0", busy_o); end
    endtask

    task automatic test_write_read_same();
        do_reset();
        s_awvalid = 4'b0001; s_wvalid = 4'b0001; s_arvalid = 4'b0011;
        s_bready = 4'hf; s_rready = 4'hf;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
        #1;
        checks++; if ({m_bready, m_rready, s_bvalid, s_rvalid} !== 10'd0) begin errors++; $display("FAIL wrongstate_resp got %010b want 0", {m_bready, m_rready, s_bvalid, s_rvalid}); end
        tick();
        checks++; if ({m_awvalid, m_arvalid, s_awready} !== 6'b10_0001) begin errors++; $display("FAIL wr_first got %06b want 100001", {m_awvalid, m_arvalid, s_awready}); end
        tick();
        s_awvalid = 4'b0000; s_wvalid = 4'b0000;
        #1;
        checks++; if (s_bvalid !== 4'b0001) begin errors++; $display("FAIL wr_first_b got %04b want 0001", s_bvalid); end
        tick();
        tick();
        checks++; if (s_arready !== 4'b0010) begin errors++; $display("FAIL rd_other got %04b want 0010", s_arready); end
        tick();
        s_arvalid = 4'b0001;
        #1;
        checks++; if (s_rvalid !== 4'b0010) begin errors++; $display("FAIL rd_other_r got %04b want 0010", s_rvalid); end
        tick();
        tick();
        checks++; if ({m_arvalid, s_arready} !== 5'b1_0001) begin errors++; $display("FAIL rd_same_later got %05b want 10001", {m_arvalid, s_arready}); end
        tick();
        s_arvalid = 4'b0000;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL same_idle got %0b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        s_arvalid = 4'b0010; m_arready = 1'b1;
        tick();
        tick();
        s_arvalid = 4'b0101; m_rvalid = 1'b1; m_rdata = 64'hdeadbeefcafef00d; m_rresp = 2'b01;
        s_rready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({busy_o, s_rvalid, m_rready} !== 6'b1_0010_0) begin errors++; $display("FAIL bp_hold c%0d got %06b want 100100", c, {busy_o, s_rvalid, m_rready}); end
            checks++; if ({s_rdata, s_rresp} !== {64'hdeadbeefcafef00d, 2'b01}) begin errors++; $display("FAIL bp_rdata c%0d got %0h/%0b want deadbeefcafef00d/01", c, s_rdata, s_rresp); end
            checks++; if (s_arready !== 4'b0000) begin errors++; $display("FAIL bp_arready c%0d got %04b want 0000", c, s_arready); end
            tick();
        end
        s_rready = 4'hf;
        #1;
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", m_rready); end
        tick();
        m_rvalid = 1'b0;
        tick();
        checks++; if (s_arready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant got %04b want 0100", s_arready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_arvalid = 4'b0100; m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 4'hf;
        tick();
        tick();
        s_arvalid = 4'b0000;
        tick();
        m_rvalid = 1'b0;
        s_awaddr[64 +: 64] = 64'haaaa_0001; s_awaddr[192 +: 64] = 64'hbbbb_0003;
        s_awvalid = 4'b1010; s_wvalid = 4'b1010;
        tick();
        checks++; if ({m_awvalid, m_awaddr} !== {1'b1, 64'hbbbb_0003}) begin errors++; $display("FAIL mid_grant3 got %0b/%0h want 1/bbbb0003", m_awvalid, m_awaddr); end
        m_awready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if ({m_awvalid, m_wvalid, busy_o, s_awready, s_wready} !== 11'd0) begin errors++; $display("FAIL mid_rst_hs got %011b want 0", {m_awvalid, m_wvalid, busy_o, s_awready, s_wready}); end
        checks++; if ({m_awaddr, m_wdata} !== 128'd0) begin errors++; $display("FAIL mid_rst_data got %0h want 0", m_awaddr); end
        tick();
        rst_n = 1'b1; m_awready = 1'b0;
        #1;
        tick();
        checks++; if ({m_awvalid, m_awaddr} !== {1'b1, 64'haaaa_0001}) begin errors++; $display("FAIL mid_ptr_reset got %0b/%0h want 1/aaaa0001", m_awvalid, m_awaddr); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_fairness();
        test_split_aw_w();
        test_write_read_same();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
